// File: rtl/fifo_stream_merger.sv
// Round-robin merger of N_CH 32-bit channels, each buffered in its own FIFO.
// Optional macro FIFO_MERGE_TAG_EN: OUT_DATA[31:28] carries the source channel.
module fifo_stream_merger #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 16
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic [N_CH-1:0]     CH_ENABLE,
  input  logic [N_CH-1:0]     CH_WRITE,
  input  logic [32*N_CH-1:0]  CH_DATA,
  output logic [N_CH-1:0]     CH_READY,
  input  logic                FIFO_NEAR_FULL,
  input  logic                OUT_READ,
  output logic                OUT_VALID,
  output logic [31:0]         OUT_DATA,
  output logic [8*N_CH-1:0]   LOST_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]     r_mem  [N_CH][DEPTH];
  logic [AW-1:0]   r_wptr [N_CH];
  logic [AW-1:0]   r_rptr [N_CH];
  logic [CW-1:0]   r_cnt  [N_CH];
  logic [7:0]      r_lost [N_CH];
  logic [N_CH-1:0] r_ready;
  logic [IW-1:0]   r_last;
  logic            r_valid;
  logic [31:0]     r_data;

  logic [N_CH-1:0] w_full;
  logic [N_CH-1:0] w_elig;
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_drop;
  logic [N_CH-1:0] w_pop;
  logic [CW-1:0]   w_cnt_nx [N_CH];
  logic            w_take;
  logic            w_load;
  logic [IW-1:0]   w_grant;
  logic [31:0]     w_word;
  logic [31:0]     w_out;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // rescues a write to a full buffer.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_full[k] = (r_cnt[k] == FULL);
      w_elig[k] = CH_ENABLE[k] & (r_cnt[k] != '0);
      w_push[k] = CH_WRITE[k] & CH_ENABLE[k] & ~w_full[k];
      w_drop[k] = CH_WRITE[k] & CH_ENABLE[k] & w_full[k];
    end
  end

  always_comb begin
    int c;
    c       = 0;
    w_load  = 1'b0;
    w_grant = '0;
    w_take  = ~r_valid | OUT_READ;
    for (int i = 1; i <= N_CH; i++) begin
      c = (int'(r_last) + i) % N_CH;
      if (!w_load && w_take && !FIFO_NEAR_FULL && w_elig[c]) begin
        w_load  = 1'b1;
        w_grant = IW'(c);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_load)
      w_pop[w_grant] = 1'b1;
    for (int k = 0; k < N_CH; k++)
      w_cnt_nx[k] = r_cnt[k] + CW'(w_push[k]) - CW'(w_pop[k]);
  end

  assign w_word = r_mem[w_grant][r_rptr[w_grant]];

`ifdef FIFO_MERGE_TAG_EN
  assign w_out = {4'(w_grant), w_word[27:0]};
`else
  assign w_out = w_word;
`endif

  always_ff @(posedge BUS_CLK) begin
    for (int k = 0; k < N_CH; k++)
      if (w_push[k])
        r_mem[k][r_wptr[k]] <= CH_DATA[32*k +: 32];
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      for (int k = 0; k < N_CH; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
        r_lost[k] <= '0;
      end
      r_ready <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_push[k])
          r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k])
          r_rptr[k] <= r_rptr[k] + 1'b1;
        r_cnt[k] <= w_cnt_nx[k];
        if (w_drop[k] && r_lost[k] != 8'hFF)
          r_lost[k] <= r_lost[k] + 8'd1;
        r_ready[k] <= CH_ENABLE[k] & (w_cnt_nx[k] != FULL);
      end
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= IW'(N_CH - 1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_out;
      r_last  <= w_grant;
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++)
      LOST_CNT[8*k +: 8] = r_lost[k];
  end

  assign CH_READY  = r_ready;
  assign OUT_VALID = r_valid;
  assign OUT_DATA  = r_data;

endmodule

// File: tb/tb_fifo_stream_merger.sv
// Bench for fifo_stream_merger: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fifo_stream_merger;

  localparam int N = 4;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   en = '0;
  logic [N-1:0]   wr = '0;
  logic [32*N-1:0] data = '0;
  logic           nf = 1'b0;
  logic           rd = 1'b0;
  logic [N-1:0]   ready;
  logic           ov;
  logic [31:0]    od;
  logic [8*N-1:0] lost;

  int n_chk = 0;
  int n_fail = 0;

  fifo_stream_merger #(.N_CH(N), .DEPTH(D)) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .CH_ENABLE(en),
    .CH_WRITE(wr),
    .CH_DATA(data),
    .CH_READY(ready),
    .FIFO_NEAR_FULL(nf),
    .OUT_READ(rd),
    .OUT_VALID(ov),
    .OUT_DATA(od),
    .LOST_CNT(lost)
  );

  always #5 clk = ~clk;

  logic [31:0] mq [N][$];
  int          mlost [N];
  bit          mv;
  logic [31:0] md;
  int          mlast;
  logic [N-1:0] mready;

  function automatic logic [31:0] tagw(int ch, logic [31:0] w);
`ifdef FIFO_MERGE_TAG_EN
    return {4'(ch), w[27:0]};
`else
    return w;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      mlost[k] = 0;
    end
    mv = 0;
    md = '0;
    mlast = N - 1;
    mready = '0;
  endtask

  // One clock edge of the merger as described by its rules.
  task automatic model_edge();
    bit take;
    bit full [N];
    int g;
    int c;
    logic [31:0] w;
    take = !mv || rd;
    g = -1;
    for (int k = 0; k < N; k++)
      full[k] = (mq[k].size() == D);
    if (take && !nf)
      for (int i = 1; i <= N; i++) begin
        c = (mlast + i) % N;
        if (g < 0 && en[c] && mq[c].size() != 0)
          g = c;
      end
    if (g >= 0) begin
      w = mq[g].pop_front();
      md = tagw(g, w);
      mv = 1;
      mlast = g;
    end else if (take) begin
      mv = 0;
    end
    for (int k = 0; k < N; k++)
      if (wr[k] && en[k]) begin
        if (!full[k])
          mq[k].push_back(data[32*k +: 32]);
        else if (mlost[k] < 255)
          mlost[k]++;
      end
    for (int k = 0; k < N; k++)
      mready[k] = en[k] && (mq[k].size() != D);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]   wr;
    logic [127:0] dat;
    logic         rd;
    logic         nf;
    logic         ev;
    logic [31:0]  ed;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0] = '{4'hF, {32'hD3, 32'hC2, 32'hB1, 32'hA0}, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b1, tagw(0, 32'hA0)};
    tbl[2] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b1, tagw(1, 32'hB1)};
    tbl[3] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b1, tagw(2, 32'hC2)};
    tbl[4] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b1, tagw(3, 32'hD3)};
    tbl[5] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 6; i++)
      tbl[6+i] = '{4'h1, {96'h0, 32'(256 + i)}, 1'b0, 1'b0,
                   (i > 0), 32'h100};
    tbl[12] = '{4'h0, 128'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{4'h0, 128'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++)
      tbl[14+i] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b1, 32'(257 + i)};
    tbl[19] = '{4'h0, 128'h0, 1'b1, 1'b0, 1'b0, 32'h0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_data", od, 32'h0);
    chk("rst_lost", lost, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    en = 4'hF;
    step();
    chk("ready_after_rst", 32'(ready), 32'hF);

    for (int i = 0; i < 20; i++) begin
      wr = tbl[i].wr;
      data = tbl[i].dat;
      rd = tbl[i].rd;
      nf = tbl[i].nf;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(ov), 32'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_data", i), od, tbl[i].ed);
    end

    // Overflow on ch2 with the output register held.
    rd = 1'b0;
    nf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr = 4'b0100;
      data = {32'h0, 32'(32'h2000 + i), 64'h0};
      step();
    end
    chk("ovf_ready2", 32'(ready[2]), 32'h0);
    chk("ovf_lost2", 32'(lost[23:16]), 32'd3);
    chk("ovf_held_valid", 32'(ov), 32'h1);
    chk("ovf_held_data", od, tagw(2, 32'h2000));
    for (int i = 0; i < 300; i++)
      step();
    chk("ovf_lost2_sat", 32'(lost[23:16]), 32'd255);
    chk("ovf_lost0", 32'(lost[7:0]), 32'd0);

    // Asynchronous reset between edges.
    wr = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov), 32'h0);
    chk("arst_data", od, 32'h0);
    chk("arst_lost", lost, 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    rd = 1'b1;
    step();
    chk("arst_ready_rel", 32'(ready), 32'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("arst_novalid%0d", i), 32'(ov), 32'h0);
    end

    // Disabled channel keeps its words but is not arbitrated.
    rd = 1'b0;
    nf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr = 4'b0010;
      data = {64'h0, 32'(32'h300 + i), 32'h0};
      step();
    end
    en = 4'b1101;
    nf = 1'b0;
    rd = 1'b1;
    data = {64'h0, 32'h3FF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("dis_valid%0d", i), 32'(ov), 32'h0);
    end
    chk("dis_ready1", 32'(ready[1]), 32'h0);
    chk("dis_lost1", 32'(lost[15:8]), 32'h0);
    en = 4'hF;
    wr = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ena_valid%0d", i), 32'(ov), 32'h1);
      chk($sformatf("ena_data%0d", i), od, tagw(1, 32'(32'h300 + i)));
    end
    step();
    chk("ena_drained", 32'(ov), 32'h0);

    // Source tag on ch3.
    wr = 4'b1000;
    data = {32'hFFFF_FFFF, 96'h0};
    step();
    wr = '0;
    chk("tag_lat1", 32'(ov), 32'h0);
    step();
    chk("tag_valid", 32'(ov), 32'h1);
`ifdef FIFO_MERGE_TAG_EN
    chk("tag_data", od, 32'h3FFF_FFFF);
`else
    chk("tag_data", od, 32'hFFFF_FFFF);
`endif
    step();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++)
        en[k] = ($urandom_range(0, 7) != 0);
      wr = 4'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom};
      nf = ($urandom_range(0, 3) == 0);
      if (cyc < 1500)
        rd = ($urandom_range(0, 3) == 0);
      else
        rd = ($urandom_range(0, 3) != 0);
      step();
      chk("rnd_valid", 32'(ov), 32'(mv));
      if (mv)
        chk("rnd_data", od, md);
      chk("rnd_ready", 32'(ready), 32'(mready));
      for (int k = 0; k < N; k++)
        chk("rnd_lost", 32'(lost[8*k +: 8]), 32'(mlost[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_merger.md
FIFO_STREAM_MERGER -- requirements
Module: fifo_stream_merger

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of 32-bit input channels (1..16).
REQ-002 SHALL have parameter DEPTH, default 16, words buffered per channel (power of 2, 2..256).
REQ-003 SHALL have port BUS_CLK  in  1  single clock for all logic.
REQ-004 SHALL have port BUS_RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port CH_ENABLE  in  N_CH  per-channel enable.
REQ-006 SHALL have port CH_WRITE  in  N_CH  per-channel write strobe, one word per high cycle.
REQ-007 SHALL have port CH_DATA  in  32*N_CH  channel k word in bits [32k+31:32k].
REQ-008 SHALL have port CH_READY  out  N_CH  channel k enabled and its buffer not full.
REQ-009 SHALL have port FIFO_NEAR_FULL  in  1  downstream throttle.
REQ-010 SHALL have port OUT_READ  in  1  downstream consumes OUT_DATA this cycle.
REQ-011 SHALL have port OUT_VALID  out  1  OUT_DATA holds a valid word.
REQ-012 SHALL have port OUT_DATA  out  32  merged word.
REQ-013 SHALL have port LOST_CNT  out  8*N_CH  per-channel dropped-word counter.

Function
REQ-014 SHALL buffer each channel in its own DEPTH-word FIFO with a count of width log2(DEPTH)+1.
REQ-015 SHALL accept a write when CH_WRITE[k]=1, CH_ENABLE[k]=1 and count<DEPTH; stored at that rising edge.
REQ-016 SHALL drop a write to a full buffer, even if the same channel is popped that cycle, and increment LOST_CNT[k], saturating at 255.
REQ-017 SHALL ignore writes to a disabled channel without counting them; stored words of that channel are retained but not arbitrated.
REQ-018 SHALL hold one output register; OUT_VALID=1 while it is loaded.
REQ-019 SHALL load the output register when it is empty, or when OUT_READ=1 and OUT_VALID=1, from the granted channel, sustaining one word per cycle.
REQ-020 SHALL grant round-robin: search starts at channel (last_grant+1) mod N_CH; only enabled, non-empty channels qualify.
REQ-021 SHALL update last_grant only when a word is actually loaded.
REQ-022 SHALL not load new words while FIFO_NEAR_FULL=1; a held word remains and is delivered on OUT_READ.
REQ-023 SHALL ignore OUT_READ while OUT_VALID=0.
REQ-024 SHALL keep OUT_DATA stable while OUT_VALID=1 and OUT_READ=0.
REQ-025 SHALL assert OUT_VALID after the second rising edge following a write into an idle merger (edge 1 store, edge 2 load).
REQ-026 SHALL register CH_READY from post-edge counts; CH_READY deasserts on the edge at which the buffer reaches DEPTH.

Reset
REQ-027 SHALL on BUS_RST, immediately and independent of BUS_CLK: clear all buffer counts and pointers, set last_grant=N_CH-1, OUT_VALID=0, OUT_DATA=0, LOST_CNT=0, CH_READY=0.
REQ-028 SHALL discard all buffered and held words when BUS_RST asserts mid-stream; CH_READY becomes CH_ENABLE on the first edge after release.

Configuration
REQ-029 SHALL, with macro FIFO_MERGE_TAG_EN defined, replace OUT_DATA[31:28] with the 4-bit source channel index; bits [27:0] unchanged.
REQ-030 SHALL, without FIFO_MERGE_TAG_EN, pass all 32 bits unmodified.

Verification
REQ-031 SHALL verify: N_CH=4, all enabled, OUT_READ=1, one write per channel in one cycle (A0,B1,C2,D3) -> output A0,B1,C2,D3 on four consecutive cycles, first OUT_VALID 2 edges after write.
REQ-032 SHALL verify: DEPTH=16, OUT_READ=0 after one word is loaded, 20 writes to ch2 -> 16 buffered, CH_READY[2]=0, LOST_CNT[2]=3; 300 further writes -> LOST_CNT[2]=255.
REQ-033 SHALL verify: FIFO_NEAR_FULL=1 with ch0 holding 5 words -> one held word delivered, then OUT_VALID=0; deassert -> remaining 4 delivered back-to-back.
REQ-034 SHALL verify: CH_ENABLE[1]=0 with 3 words stored in ch1, writes to ch1 -> none delivered, LOST_CNT[1] unchanged; re-enable -> 3 words delivered.
REQ-035 SHALL verify: BUS_RST pulsed mid-stream between clock edges -> OUT_VALID, LOST_CNT, counts 0 before the next edge; no pre-reset word appears afterward.
REQ-036 SHALL verify: FIFO_MERGE_TAG_EN defined, word 0xFFFFFFFF written on ch3 -> OUT_DATA=0x3FFFFFFF; undefined -> 0xFFFFFFFF.
